// File: rtl/yarr_rx_pkg.sv
// Shared definitions for the receive path: sync-header codes, block geometry
// and the block aligner state encoding.
package yarr_rx_pkg;

    localparam logic [1:0] c_DATA_HEADER = 2'b01;
    localparam logic [1:0] c_CMD_HEADER  = 2'b10;
    localparam int         c_BLOCK_W     = 66;
    localparam int         c_MAX_OFFSET  = 65;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} align_state_t;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
    endfunction

endpackage

// File: rtl/block_slicer.sv
// Combinational extraction of one 66b block (2b header + 64b payload) from the
// gearbox buffer; the header MSB sits at 128 - gbox_cnt + offset.
module block_slicer
    import yarr_rx_pkg::*;
(
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    input  logic [6:0]   offset,
    output logic [1:0]   header,
    output logic [63:0]  payload
);

    logic [7:0]  hdr_msb;
    logic [7:0]  shift;
    logic [65:0] block;

    // Shifting the block's LSB down to bit 0 keeps every access in range,
    // even for an illegal offset.
    always_comb begin
        hdr_msb = 8'd128 - {2'b00, gbox_cnt} + {1'b0, offset};
        shift   = hdr_msb - 8'(c_BLOCK_W - 1);
        block   = 66'(gbox_buffer >> shift);
        header  = block[65:64];
        payload = block[63:0];
    end

endmodule

// File: rtl/block_aligner.sv
// Qualifies the header seeker's offset through HUNT/CHECK/LOCKED and, once
// locked, emits one aligned 66b block per gearbox buffer update.
module block_aligner
    import yarr_rx_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int LOCK_CNT   = 32,
    parameter int BAD_WIN    = 64,
    parameter int BAD_MAX    = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    input  logic         buffer_dv,
    input  logic [6:0]   block_offset,
    output logic [63:0]  block_o,
    output logic [1:0]   header_o,
    output logic         block_dv_o,
    output logic         locked_o,
    output logic [7:0]   lock_loss_cnt_o,
    output logic [1:0]   state_o
);

    localparam int SW = $clog2(STABLE_CNT);
    localparam int GW = $clog2(LOCK_CNT);
    localparam int WW = $clog2(BAD_WIN);
    localparam int XW = $clog2(BAD_MAX + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(BAD_WIN - 1);
    localparam logic [XW-1:0] BAD_LIMIT   = XW'(BAD_MAX);

    align_state_t  state;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;
    logic [6:0]    prev_off;
    logic [6:0]    cur_off;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] blk_cnt;
    logic [XW-1:0] bad_cnt;
    logic [XW-1:0] bad_nxt;
    logic [1:0]    slice_hdr;
    logic [63:0]   slice_payload;
    logic          hdr_ok;
    logic          off_match;

    block_slicer u_slicer (
        .gbox_buffer (gbox_buffer),
        .gbox_cnt    (gbox_cnt),
        .offset      (cur_off),
        .header      (slice_hdr),
        .payload     (slice_payload)
    );

    always_comb begin
        hdr_ok    = hdr_valid(slice_hdr);
        off_match = (block_offset <= 7'(c_MAX_OFFSET)) && (block_offset == prev_off);
        stable_nxt = stable_cnt;
        if (stable_cnt != STABLE_LAST) begin
            stable_nxt = stable_cnt + 1'b1;
        end
        bad_nxt = bad_cnt;
        if (!hdr_ok && (bad_cnt != BAD_LIMIT)) begin
            bad_nxt = bad_cnt + 1'b1;
        end
    end

    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= HUNT;
            stable_cnt      <= '0;
            prev_off        <= '0;
            cur_off         <= '0;
            good_cnt        <= '0;
            blk_cnt         <= '0;
            bad_cnt         <= '0;
            lock_loss_cnt_o <= '0;
            block_o         <= '0;
            header_o        <= '0;
            block_dv_o      <= 1'b0;
            locked_o        <= 1'b0;
        end else begin
            locked_o   <= (state == LOCKED);
            block_dv_o <= 1'b0;
            if (buffer_dv) begin
                case (state)
                    HUNT: begin
                        if (off_match) begin
                            stable_cnt <= stable_nxt;
                            if (stable_nxt == STABLE_LAST) begin
                                cur_off  <= block_offset;
                                good_cnt <= '0;
                                state    <= CHECK;
                            end
                        end else begin
                            stable_cnt <= '0;
                            prev_off   <= block_offset;
                        end
                    end
                    CHECK: begin
                        if (!hdr_ok) begin
                            stable_cnt <= '0;
                            state      <= HUNT;
                        end else if (good_cnt == GOOD_LAST) begin
                            blk_cnt <= '0;
                            bad_cnt <= '0;
                            state   <= LOCKED;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        // The block is emitted even when it is the one that breaks lock.
                        block_dv_o <= 1'b1;
                        block_o    <= slice_payload;
                        header_o   <= slice_hdr;
                        if (bad_nxt == BAD_LIMIT) begin
                            stable_cnt <= '0;
                            state      <= HUNT;
                            if (lock_loss_cnt_o != 8'hFF) begin
                                lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
                            end
                        end else if (blk_cnt == WIN_LAST) begin
                            blk_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                            bad_cnt <= bad_nxt;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_aligner.sv
// Directed and randomized checks of block_aligner against a sample/header
// counting reference model.
module tb_block_aligner;
    import yarr_rx_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [193:0] gbox_buffer;
    logic [5:0]   gbox_cnt;
    logic         buffer_dv;
    logic [6:0]   block_offset;
    logic [63:0]  block_o;
    logic [1:0]   header_o;
    logic         block_dv_o;
    logic         locked_o;
    logic [7:0]   lock_loss_cnt_o;
    logic [1:0]   state_o;

    always #5 clk_i = ~clk_i;

    block_aligner dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .gbox_buffer     (gbox_buffer),
        .gbox_cnt        (gbox_cnt),
        .buffer_dv       (buffer_dv),
        .block_offset    (block_offset),
        .block_o         (block_o),
        .header_o        (header_o),
        .block_dv_o      (block_dv_o),
        .locked_o        (locked_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .state_o         (state_o)
    );

    int tests;
    int fails;
    int dv_seen;

    // Reference model: mode 0 hunting, 1 checking, 2 locked.
    int          m_mode;
    int          m_last;
    int          m_run;
    int          m_good;
    int          m_blk;
    int          m_bad;
    int          m_loss;
    int          m_off;
    logic [63:0] e_block;
    logic [1:0]  e_hdr;
    logic        e_dv;
    logic        e_locked;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_last   = 0;
        m_run    = 1;
        m_good   = 0;
        m_blk    = 0;
        m_bad    = 0;
        m_loss   = 0;
        m_off    = 0;
        e_block  = '0;
        e_hdr    = '0;
        e_dv     = 1'b0;
        e_locked = 1'b0;
    endtask

    function automatic logic [65:0] ref_slice(input logic [193:0] b, input int cnt, input int off);
        logic [65:0] r;
        int h;
        h = 128 - cnt + off;
        for (int i = 0; i < 66; i++) r[65-i] = b[h-i];
        return r;
    endfunction

    function automatic logic [193:0] make_buffer(input int cnt, input int hoff, input logic [1:0] hdr);
        logic [193:0] b;
        int h;
        for (int i = 0; i < 194; i++) b[i] = 1'($urandom_range(0, 1));
        h = 128 - cnt + hoff;
        b[h]   = hdr[1];
        b[h-1] = hdr[0];
        return b;
    endfunction

    function automatic logic [1:0] rand_hdr(input logic bad);
        logic [1:0] h;
        if (bad) h = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        else     h = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        return h;
    endfunction

    task automatic step(input logic dv, input int cnt, input int off, input int hoff, input logic [1:0] hdr);
        logic [193:0] b;
        logic [65:0]  s;
        logic         ok;
        b = make_buffer(cnt, hoff, hdr);
        buffer_dv    = dv;
        gbox_cnt     = 6'(cnt);
        block_offset = 7'(off);
        gbox_buffer  = b;
        e_locked = (m_mode == 2);
        e_dv     = 1'b0;
        if (dv) begin
            s  = ref_slice(b, cnt, m_off);
            ok = (s[65:64] == 2'b01) || (s[65:64] == 2'b10);
            case (m_mode)
                0: begin
                    if (off <= 65 && off == m_last) m_run++;
                    else m_run = 1;
                    m_last = off;
                    if (m_run == 4) begin
                        m_mode = 1;
                        m_off  = off;
                        m_good = 0;
                    end
                end
                1: begin
                    if (ok) begin
                        m_good++;
                        if (m_good == 32) begin
                            m_mode = 2;
                            m_blk  = 0;
                            m_bad  = 0;
                        end
                    end else begin
                        m_mode = 0;
                        m_run  = 1;
                        m_last = m_off;
                    end
                end
                default: begin
                    e_dv    = 1'b1;
                    e_block = s[63:0];
                    e_hdr   = s[65:64];
                    m_blk++;
                    if (!ok) m_bad++;
                    if (m_bad == 16) begin
                        m_mode = 0;
                        m_run  = 1;
                        m_last = m_off;
                        if (m_loss < 255) m_loss++;
                    end else if (m_blk == 64) begin
                        m_blk = 0;
                        m_bad = 0;
                    end
                end
            endcase
        end
        @(posedge clk_i);
        #1;
        if (block_dv_o === 1'b1) dv_seen++;
        check("block_dv", 64'(block_dv_o), 64'(e_dv));
        check("locked", 64'(locked_o), 64'(e_locked));
        check("loss_cnt", 64'(lock_loss_cnt_o), 64'(m_loss));
        check("state", 64'(state_o), 64'(m_mode));
        check("block", block_o, e_block);
        check("header", 64'(header_o), 64'(e_hdr));
    endtask

    task automatic acquire(input int cnt, input int off);
        int guard;
        guard = 0;
        while (m_mode != 2 && guard < 80) begin
            step(1'b1, cnt, off, off, rand_hdr(1'b0));
            guard++;
        end
        check("acquire_state", 64'(state_o), 64'(2));
        repeat (20) step(1'b1, cnt, off, off, rand_hdr(1'b0));
        check("acquire_locked", 64'(locked_o), 64'(1));
    endtask

    initial begin
        int guard;
        tests = 0;
        fails = 0;
        dv_seen = 0;
        rst_ni = 1'b0;
        buffer_dv = 1'b0;
        gbox_buffer = '0;
        gbox_cnt = '0;
        block_offset = '0;
        model_reset();

        // Reset and idle
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_block", block_o, 64'(0));
        check("rst_header", 64'(header_o), 64'(0));
        check("rst_dv", 64'(block_dv_o), 64'(0));
        check("rst_locked", 64'(locked_o), 64'(0));
        check("rst_loss", 64'(lock_loss_cnt_o), 64'(0));
        check("rst_state", 64'(state_o), 64'(0));
        rst_ni = 1'b1;
        repeat (100) step(1'b0, $urandom_range(0, 63), 17, 17, rand_hdr(1'b0));
        check("idle_state", 64'(state_o), 64'(0));

        // Alternating offset never qualifies
        dv_seen = 0;
        for (int i = 0; i < 40; i++)
            step(1'b1, $urandom_range(0, 63), (i % 2 == 1) ? 18 : 17, 17, rand_hdr(1'b0));
        check("unstable_dv_seen", 64'(dv_seen), 64'(0));
        check("unstable_state", 64'(state_o), 64'(0));
        check("unstable_locked", 64'(locked_o), 64'(0));

        // Invalid header on the 10th CHECK block
        guard = 0;
        while (m_mode != 1 && guard < 10) begin
            step(1'b1, $urandom_range(0, 63), 5, 5, rand_hdr(1'b0));
            guard++;
        end
        check("enter_check", 64'(state_o), 64'(1));
        repeat (9) step(1'b1, $urandom_range(0, 63), 5, 5, rand_hdr(1'b0));
        step(1'b1, $urandom_range(0, 63), 5, 5, 2'b11);
        check("check_fail_state", 64'(state_o), 64'(0));
        check("check_fail_loss", 64'(lock_loss_cnt_o), 64'(0));

        // Clean acquisition at 17: 4 samples + 32 headers, locked_o one later
        repeat (36) step(1'b1, $urandom_range(0, 63), 17, 17, rand_hdr(1'b0));
        check("acq_state", 64'(state_o), 64'(2));
        check("acq_locked_lag", 64'(locked_o), 64'(0));
        step(1'b1, $urandom_range(0, 63), 17, 17, rand_hdr(1'b0));
        check("acq_locked", 64'(locked_o), 64'(1));
        check("acq_first_dv", 64'(block_dv_o), 64'(1));
        repeat (63) step(1'b1, $urandom_range(0, 63), 17, 17, rand_hdr(1'b0));

        // 15 bad per window, last one on the window's final block
        for (int i = 0; i < 256; i++)
            step(1'b1, $urandom_range(0, 63), 17, 17, rand_hdr((i % 64) >= 49));
        check("win15_locked", 64'(locked_o), 64'(1));
        check("win15_loss", 64'(lock_loss_cnt_o), 64'(0));

        // 16 bad in one window, the 16th on the final block
        for (int i = 0; i < 64; i++)
            step(1'b1, $urandom_range(0, 63), 17, 17, rand_hdr(i >= 48));
        check("loss_last_dv", 64'(block_dv_o), 64'(1));
        check("loss_state", 64'(state_o), 64'(0));
        check("loss_cnt", 64'(lock_loss_cnt_o), 64'(1));
        step(1'b0, 0, 17, 17, rand_hdr(1'b0));
        check("loss_locked", 64'(locked_o), 64'(0));

        // Lowest header position, then asynchronous reset while streaming
        acquire(63, 0);
        check("pre_rst_dv", 64'(block_dv_o), 64'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_locked", 64'(locked_o), 64'(0));
        check("async_dv", 64'(block_dv_o), 64'(0));
        check("async_loss", 64'(lock_loss_cnt_o), 64'(0));
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Highest header position
        acquire(0, 65);

        // Randomized traffic with gaps, occasional bad headers and offset noise
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 63),
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, 127) : 33, 33,
                 rand_hdr($urandom_range(0, 29) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/block_aligner.md
Name: block_aligner

Overview:
- Sits directly downstream of header_seeker and shares the gearbox buffer with it.
- Qualifies the seeker's proposed block_offset and runs a hunt/check/lock state machine on it.
- Once locked, slices one aligned 66b block (2b header + 64b payload) out of the 194b gearbox buffer per valid buffer update.
- Feeds the descrambler/decoder and reports lock status to the register bank.

Parameters:
- STABLE_CNT, 4: consecutive identical block_offset samples required to leave HUNT.
- LOCK_CNT, 32: consecutive valid headers in CHECK required to enter LOCKED.
- BAD_WIN, 64: LOCKED-state monitoring window length, in blocks.
- BAD_MAX, 16: bad headers within one window that force loss of lock.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- gbox_buffer  in  194  complete gearbox buffer.
- gbox_cnt  in  6  gearbox view window index.
- buffer_dv  in  1  gbox_buffer/gbox_cnt valid this cycle.
- block_offset  in  7  header offset proposed by header_seeker (legal range 0..65).
- block_o  out  64  aligned payload.
- header_o  out  2  aligned sync header.
- block_dv_o  out  1  block_o/header_o valid, one-cycle pulse.
- locked_o  out  1  aligner is in LOCKED.
- lock_loss_cnt_o  out  8  saturating count of LOCKED->HUNT transitions.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. Reset clears all state: FSM=HUNT, all counters 0, latched offset 0, and every output 0.
- All state updates occur only on cycles with buffer_dv=1; otherwise everything holds.
- Slicing: given an offset o, the header MSB bit index is h = 128 - gbox_cnt + o.
  - Block = gbox_buffer[h -: 66]; header = [h -: 2]; payload = [h-2 -: 64].
  - For o in 0..65, h lies in 65..193 for every gbox_cnt, so the slice is always in range.
  - Arithmetic uses 8b unsigned.
- Header is valid iff it equals 2'b01 (data) or 2'b10 (cmd).
- HUNT:
  - If block_offset <= 65 and equals the previous sample, stable_cnt increments (saturating). Otherwise stable_cnt is cleared and block_offset is captured as the comparison sample.
  - When stable_cnt reaches STABLE_CNT-1 on a matching sample: latch block_offset into cur_off, clear good_cnt, go to CHECK.
  - block_offset > 65 is always a mismatch.
- CHECK:
  - Slice at cur_off. Valid header: good_cnt++.
  - good_cnt reaching LOCK_CNT-1 on a valid header goes to LOCKED with blk_cnt=bad_cnt=0.
  - Any invalid header goes to HUNT with stable_cnt=0.
  - Changes on block_offset are ignored in CHECK.
- LOCKED:
  - Slice at cur_off and count blocks. Invalid header: bad_cnt++ (saturating at BAD_MAX).
  - If the updated bad_cnt reaches BAD_MAX: go to HUNT and increment lock_loss_cnt_o (saturating at 255).
  - Otherwise, at the end of each window (blk_cnt = BAD_WIN-1), clear blk_cnt and bad_cnt.
  - A bad header on the last block of a window is counted before the BAD_MAX test.
  - block_offset is ignored; cur_off never changes while locked.
- Output stage:
  - block_dv_o, block_o and header_o are registered one cycle after a buffer_dv on which the FSM is in LOCKED, pre-transition. The block that causes loss of lock is still emitted.
  - block_o and header_o hold their values while block_dv_o=0.
- locked_o is high one cycle after the FSM register enters LOCKED and low one cycle after it leaves.
- rst_ni asserted mid-block drops block_dv_o and locked_o immediately (asynchronously).

Decomposition:
- Shared package yarr_rx_pkg contains:
  - c_DATA_HEADER and c_CMD_HEADER;
  - c_BLOCK_W=66 and c_MAX_OFFSET=65;
  - the enum align_state_t {HUNT, CHECK, LOCKED};
  - the function hdr_valid(logic [1:0]).
- One sub-module, block_slicer, is natural. It is purely combinational: gbox_buffer, gbox_cnt and offset in; 2b header and 64b payload out. It is reused by the decoder test harness.

Test Plan:
- Reset/idle: hold rst_ni=0 → all outputs 0. Release, no buffer_dv for 100 cycles → outputs stay 0, FSM stays HUNT.
- Clean acquisition: stream with header at o=17, block_offset constant 17 → locked_o rises after 4+32 dv cycles (+1). block_dv_o follows each subsequent dv by 1 cycle, with header_o in {01,10} and block_o matching the reference payload.
- Unstable offset: block_offset alternates 17/18 each dv → FSM never leaves HUNT, locked_o=0, block_dv_o never asserts.
- Check failure: offset stable at 5, then a 2'b11 header at the 10th CHECK block → return to HUNT, lock_loss_cnt_o unchanged at 0.
- Loss of lock:
  - Inject 16 bad headers in one 64-block window → locked_o falls, lock_loss_cnt_o=1.
  - 15 bad per window repeated over 4 windows → stays locked.
- Boundary slices: offset=0 with gbox_cnt=63 (h=65), and offset=65 with gbox_cnt=0 (h=193) → lock and output payloads match the model with no out-of-range access. Assert rst_ni low mid-stream → locked_o falls in the same cycle.
